// File: rtl/eth_rx_pkt_buf_ctrl.sv
// Ethernet RX packet FIFO controller around an external 1r1w sync-read RAM.
// Packets commit on a good last beat; bad or overflowed packets are rewound.
module eth_rx_pkt_buf_ctrl #(
  parameter int width_p = 32,
  parameter int els_p = 64,
  parameter int ptr_width_lp = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    wr_v_i,
  input  logic [width_p-1:0]      wr_data_i,
  input  logic                    wr_last_i,
  input  logic                    wr_err_i,
  output logic                    mem_w_v_o,
  output logic [ptr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p:0]        mem_w_data_o,
  output logic                    mem_r_v_o,
  output logic [ptr_width_lp-1:0] mem_r_addr_o,
  input  logic [width_p:0]        mem_r_data_i,
  output logic                    rd_v_o,
  output logic [width_p-1:0]      rd_data_o,
  output logic                    rd_last_o,
  input  logic                    rd_yumi_i,
  output logic                    pkt_commit_o,
  output logic                    pkt_drop_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DISCARD
  } state_t;

  localparam logic [ptr_width_lp:0] depth =
    (ptr_width_lp+1)'(els_p);

  state_t state;
  logic [ptr_width_lp:0] wr_ptr;
  logic [ptr_width_lp:0] cmt_ptr;
  logic [ptr_width_lp:0] rd_ptr;
  logic commit_q;
  logic drop_q;

  logic full;
  logic avail;
  logic accept;

  assign full = (wr_ptr - rd_ptr) == depth;
  assign avail = cmt_ptr != rd_ptr;
  assign accept = wr_v_i & !full
                & (state != DISCARD) & !reset_i;

  assign mem_w_v_o = accept;
  assign mem_w_addr_o = wr_ptr[ptr_width_lp-1:0];
  assign mem_w_data_o = accept ? {wr_last_i, wr_data_i} : '0;
  assign pkt_commit_o = commit_q;
  assign pkt_drop_o = drop_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      wr_ptr <= '0;
      cmt_ptr <= '0;
      commit_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      drop_q <= 1'b0;
      if (wr_v_i) begin
        unique case (state)
          IDLE, ACTIVE: begin
            if (full) begin
              wr_ptr <= cmt_ptr;
              drop_q <= 1'b1;
              state <= wr_last_i ? IDLE : DISCARD;
            end else if (!wr_last_i) begin
              wr_ptr <= wr_ptr + 1'b1;
              state <= ACTIVE;
            end else if (wr_err_i) begin
              wr_ptr <= cmt_ptr;
              drop_q <= 1'b1;
              state <= IDLE;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              cmt_ptr <= wr_ptr + 1'b1;
              commit_q <= 1'b1;
              state <= IDLE;
            end
          end
          DISCARD: begin
            if (wr_last_i) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read side: in-flight RAM data bypasses an empty buffer.
  logic inflight;
  logic [1:0] count;
  logic head;
  logic tail;
  logic [width_p:0] fifo_q [2];
  logic [width_p:0] head_data;
  logic [1:0] occ;
  logic issue;
  logic pop;
  logic push;
  logic pop_buf;

  assign occ = count + {1'b0, inflight};
  assign issue = avail & (occ < 2'd2);
  assign mem_r_v_o = issue;
  assign mem_r_addr_o = rd_ptr[ptr_width_lp-1:0];

  assign head_data = (count != 2'd0) ? fifo_q[head]
                                     : mem_r_data_i;
  assign rd_v_o = (count != 2'd0) | inflight;
  assign rd_data_o = rd_v_o ? head_data[width_p-1:0] : '0;
  assign rd_last_o = rd_v_o & head_data[width_p];

  assign pop = rd_yumi_i & rd_v_o;
  assign pop_buf = pop & (count != 2'd0);
  assign push = inflight & !(pop & (count == 2'd0));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      inflight <= 1'b0;
      count <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      inflight <= issue;
      if (push) tail <= ~tail;
      if (pop_buf) head <= ~head;
      unique case ({push, pop_buf})
        2'b10: count <= count + 2'd1;
        2'b01: count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[tail] <= mem_r_data_i;
  end

  a_yumi_legal: assert property (
    @(posedge clk_i) disable iff (reset_i)
    !(rd_yumi_i && !rd_v_o));

  a_els_pow2: assert property (
    @(posedge clk_i) (els_p & (els_p - 1)) == 0);

endmodule
